// File: rtl/rob_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rob_wb_arbiter_if
// Bundles the writeback-arbiter bus: the per-source result inputs with their
// ready flags, the pipeline flush, and the ROB writeback ports.
//   slave  : arbiter side (consumes src_*, flush; drives src_ready, wb_*)
//   master : execution-unit / ROB side (the opposite directions)
// Optional macro ROBWB_PERF_CNT_EN adds the perf_wb_count and
// perf_stall_count signals to the bundle.
// -----------------------------------------------------------------------------
interface rob_wb_arbiter_if #(
   parameter int NUM_SRC         = 4,
   parameter int NUM_PORTS       = 2,
   parameter int ROB_ADDR_WIDTH  = 4,
   parameter int BANK_ADDR_WIDTH = 1,
   parameter int PREG_WIDTH      = 6
);
   logic                                 flush;
   logic [NUM_SRC-1:0]                   src_valid;
   logic [NUM_SRC-1:0]                   src_ready;
   logic [NUM_SRC*ROB_ADDR_WIDTH-1:0]    src_rob_addr;
   logic [NUM_SRC*BANK_ADDR_WIDTH-1:0]   src_bank_addr;
   logic [NUM_SRC*PREG_WIDTH-1:0]        src_phys_rd;
   logic [NUM_SRC-1:0]                   src_is_branch;
   logic [NUM_SRC-1:0]                   src_taken;

   logic [NUM_PORTS-1:0]                 wb_en;
   logic [NUM_PORTS*ROB_ADDR_WIDTH-1:0]  wb_rob_addr;
   logic [NUM_PORTS*BANK_ADDR_WIDTH-1:0] wb_bank_addr;
   logic [NUM_PORTS*PREG_WIDTH-1:0]      wb_phys_rd;
   logic [NUM_PORTS-1:0]                 wb_is_branch;
   logic [NUM_PORTS-1:0]                 wb_taken;
`ifdef ROBWB_PERF_CNT_EN
   logic [31:0]                          perf_wb_count;
   logic [31:0]                          perf_stall_count;
`endif

   modport slave (
      input  flush, src_valid, src_rob_addr, src_bank_addr, src_phys_rd,
             src_is_branch, src_taken,
      output src_ready, wb_en, wb_rob_addr, wb_bank_addr, wb_phys_rd,
             wb_is_branch, wb_taken
`ifdef ROBWB_PERF_CNT_EN
      , output perf_wb_count, perf_stall_count
`endif
   );

   modport master (
      output flush, src_valid, src_rob_addr, src_bank_addr, src_phys_rd,
             src_is_branch, src_taken,
      input  src_ready, wb_en, wb_rob_addr, wb_bank_addr, wb_phys_rd,
             wb_is_branch, wb_taken
`ifdef ROBWB_PERF_CNT_EN
      , input perf_wb_count, perf_stall_count
`endif
   );
endinterface

// File: rtl/rob_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rob_wb_arbiter
// Buffers completion writebacks from NUM_SRC execution units in per-source
// FIFOs and forwards up to NUM_PORTS of them per cycle to the ROB writeback
// ports, chosen round-robin starting at rr_ptr. Outputs are registered, so a
// writeback accepted at edge t appears on wb_* after edge t+1.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (also flushes, clears wb_* fields)
//   wb_bus : rob_wb_arbiter_if.slave (flush, src_* inputs, src_ready, wb_*)
// Optional macro ROBWB_PERF_CNT_EN adds saturating 32-bit perf_wb_count and
// perf_stall_count outputs on wb_bus.
// -----------------------------------------------------------------------------
module rob_wb_arbiter #(
   parameter int NUM_SRC         = 4,
   parameter int NUM_PORTS       = 2,
   parameter int BUF_DEPTH       = 4,
   parameter int ROB_ADDR_WIDTH  = 4,
   parameter int BANK_ADDR_WIDTH = 1,
   parameter int PREG_WIDTH      = 6
) (
   input logic             clk,
   input logic             rst,
   rob_wb_arbiter_if.slave wb_bus
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef struct packed {
      logic [ROB_ADDR_WIDTH-1:0]  rob_addr;
      logic [BANK_ADDR_WIDTH-1:0] bank_addr;
      logic [PREG_WIDTH-1:0]      phys_rd;
      logic                       is_branch;
      logic                       taken;
   } entry_t;

   entry_t           r_mem    [NUM_SRC][BUF_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr [NUM_SRC];
   logic [PTR_W-1:0] r_rd_ptr [NUM_SRC];
   logic [CNT_W-1:0] r_count  [NUM_SRC];
   logic [SRC_W-1:0] r_rr_ptr;
   entry_t           r_wb     [NUM_PORTS];
   logic [NUM_PORTS-1:0] r_wb_en;

   logic [NUM_SRC-1:0]   w_ready;
   logic [NUM_SRC-1:0]   w_push;
   logic [NUM_SRC-1:0]   w_pop;
   entry_t               w_src_ent  [NUM_SRC];
   logic [SRC_W-1:0]     w_port_src [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_port_vld;
   logic [SRC_W-1:0]     w_rr_next;

   // Input side: ready depends only on registered count, never on this
   // cycle's pop, so a full FIFO refuses a push even while being drained.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_ready[i]   = !rst && (r_count[i] < CNT_W'(BUF_DEPTH));
      assign w_push[i]    = wb_bus.src_valid[i] && w_ready[i] && !wb_bus.flush;
      assign w_src_ent[i] = '{
         rob_addr:  wb_bus.src_rob_addr[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH],
         bank_addr: wb_bus.src_bank_addr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH],
         phys_rd:   wb_bus.src_phys_rd[i*PREG_WIDTH +: PREG_WIDTH],
         is_branch: wb_bus.src_is_branch[i],
         taken:     wb_bus.src_taken[i]
      };
   end
   assign wb_bus.src_ready = w_ready;

   // Round-robin scan from rr_ptr; the g-th non-empty FIFO found feeds port g.
   always_comb begin
      int               n_grant;
      logic [SRC_W-1:0] idx;
      n_grant    = 0;
      idx        = '0;
      w_pop      = '0;
      w_port_vld = '0;
      w_rr_next  = r_rr_ptr;
      for (int p = 0; p < NUM_PORTS; p++) w_port_src[p] = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
         if (r_count[idx] != '0 && n_grant < NUM_PORTS) begin
            w_pop[idx]          = 1'b1;
            w_port_src[n_grant] = idx;
            w_port_vld[n_grant] = 1'b1;
            n_grant             = n_grant + 1;
            w_rr_next           = (int'(idx) + 1 == NUM_SRC) ? '0 : idx + 1'b1;
         end
      end
   end

   // NOTE: FIFO storage is deliberately not reset; r_count gates every read,
   // so stale contents are never observed and the array stays plain RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_src_ent[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_count[i]  <= '0;
         end
         for (int p = 0; p < NUM_PORTS; p++) r_wb[p] <= '0;
         r_wb_en  <= '0;
         r_rr_ptr <= '0;
      end else if (wb_bus.flush) begin
         // Flush drops everything buffered; output fields keep their value
         // but are qualified off by wb_en.
         for (int i = 0; i < NUM_SRC; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_count[i]  <= '0;
         end
         r_wb_en  <= '0;
         r_rr_ptr <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
            if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
            case ({w_push[i], w_pop[i]})
               2'b10:   r_count[i] <= r_count[i] + 1'b1;
               2'b01:   r_count[i] <= r_count[i] - 1'b1;
               default: r_count[i] <= r_count[i];
            endcase
         end
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_wb_en[p] <= w_port_vld[p];
            r_wb[p]    <= w_port_vld[p] ?
                          r_mem[w_port_src[p]][r_rd_ptr[w_port_src[p]]] : '0;
         end
         if (|w_port_vld) r_rr_ptr <= w_rr_next;
      end
   end

   assign wb_bus.wb_en = r_wb_en;
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign wb_bus.wb_rob_addr[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]    = r_wb[p].rob_addr;
      assign wb_bus.wb_bank_addr[p*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = r_wb[p].bank_addr;
      assign wb_bus.wb_phys_rd[p*PREG_WIDTH +: PREG_WIDTH]             = r_wb[p].phys_rd;
      assign wb_bus.wb_is_branch[p]                                    = r_wb[p].is_branch;
      assign wb_bus.wb_taken[p]                                        = r_wb[p].taken;
   end

`ifdef ROBWB_PERF_CNT_EN
   logic [31:0] r_perf_wb;
   logic [31:0] r_perf_stall;
   logic [32:0] w_wb_sum;
   logic        w_stall;

   // Grants in a flush cycle never reach the ROB, so they are not counted.
   assign w_wb_sum = {1'b0, r_perf_wb} +
                     33'($countones(w_port_vld & {NUM_PORTS{!wb_bus.flush}}));
   assign w_stall  = |(wb_bus.src_valid & ~w_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_wb    <= '0;
         r_perf_stall <= '0;
      end else begin
         r_perf_wb <= w_wb_sum[32] ? '1 : w_wb_sum[31:0];
         if (w_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
      end
   end

   assign wb_bus.perf_wb_count    = r_perf_wb;
   assign wb_bus.perf_stall_count = r_perf_stall;
`endif
endmodule
